// File: rtl/au_cnt_gray.sv
// Gray-code up/down counter with load and a wrap or saturate mode at the ends of the range.
// z is the registered Gray count, zb its combinational binary decode, co the registered end-of-range flag.
module au_cnt_gray #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             ci,
    input  logic             dn,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] zb,
    output logic             co
);
    // Gray code of the largest binary value: only the MSB set.
    localparam logic [WIDTH-1:0] GTOP   = WIDTH'(1) << (WIDTH - 1);
    localparam bit               SAT_EN = (SAT == 1);

    logic [WIDTH-1:0] step;
    logic             at_end;

    if (WIDTH < 1) begin : g_bad_width
        $error("au_cnt_gray: illegal parameter WIDTH=%0d (legal: >= 1)", WIDTH);
    end
    if (SAT < 0 || SAT > 1) begin : g_bad_sat
        $error("au_cnt_gray: illegal parameter SAT=%0d (legal: 0..1)", SAT);
    end

    always_comb begin
        zb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            zb[i] = ^(z >> i);
        end
    end

    assign at_end = dn ? (z == '0) : (z == GTOP);

    // All three variants produce the wrapping neighbour of z in the direction dn.
    if (ARCH == 0) begin : g_arith
        logic [WIDTH-1:0] nb;
        assign nb   = dn ? (zb - WIDTH'(1)) : (zb + WIDTH'(1));
        assign step = nb ^ (nb >> 1);
    end else if (ARCH == 1) begin : g_scan
        logic             par;
        logic             found;
        logic [WIDTH-1:0] flip;
        assign par = ^z;
        // Even parity going up (odd going down) flips bit 0; otherwise the bit left of the lowest one.
        always_comb begin
            flip  = '0;
            found = 1'b0;
            if (par == dn) begin
                flip[0] = 1'b1;
            end else begin
                for (int i = 0; i < WIDTH - 1; i++) begin
                    if (!found && z[i]) begin
                        flip[i+1] = 1'b1;
                        found     = 1'b1;
                    end
                end
                if (!found) begin
                    flip[WIDTH-1] = 1'b1;
                end
            end
        end
        assign step = z ^ flip;
    end else if (ARCH == 2) begin : g_isolate
        logic             par;
        logic [WIDTH-1:0] lsb;
        logic [WIDTH-1:0] left;
        logic [WIDTH-1:0] flip;
        assign par  = ^z;
        assign lsb  = z & (~z + WIDTH'(1));
        assign left = lsb << 1;
        assign flip = (par == dn) ? WIDTH'(1) : ((left == '0) ? GTOP : left);
        assign step = z ^ flip;
    end else begin : g_bad_arch
        $error("au_cnt_gray: illegal parameter ARCH=%0d (legal: 0..2)", ARCH);
        assign step = z;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z  <= '0;
            co <= 1'b0;
        end else if (ld) begin
            z  <= d;
            co <= 1'b0;
        end else if (ci) begin
            co <= at_end;
            if (!(at_end && SAT_EN)) begin
                z <= step;
            end
        end else begin
            co <= 1'b0;
        end
    end
endmodule

// File: tb/tb_au_cnt_gray.sv
// Bench for au_cnt_gray: several configurations share one random stimulus stream,
// each checked by a binary-count scoreboard, plus directed WIDTH=4 checks.
module tb_au_cnt_gray;
    localparam int NC = 10;
    localparam int CW [NC] = '{4, 4, 4, 4, 1, 1, 8, 8, 13, 13};
    localparam int CA [NC] = '{0, 1, 2, 2, 1, 0, 2, 1, 0, 2};
    localparam int CS [NC] = '{0, 1, 0, 1, 0, 1, 1, 0, 0, 1};

    typedef struct packed {
        logic [12:0] z;
        logic [12:0] zb;
        logic        co;
        logic        sb;
        logic [1:0]  hops;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld  = 1'b0;
    logic [12:0] d   = '0;
    logic        ci  = 1'b0;
    logic        dn  = 1'b0;

    logic [12:0] zo  [NC];
    logic [12:0] zbo [NC];
    logic        coo [NC];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
        end else begin
            passes++;
        end
    endtask

    function automatic longint g2b(input logic [12:0] v, input int w);
        longint b;
        logic   acc;
        b   = 0;
        acc = 1'b0;
        for (int k = w - 1; k >= 0; k--) begin
            acc = acc ^ v[k];
            if (acc) b = b | (longint'(1) << k);
        end
        return b;
    endfunction

    for (genvar i = 0; i < NC; i++) begin : g
        localparam int W = CW[i];
        logic [W-1:0] z;
        logic [W-1:0] zb;
        logic         co;

        au_cnt_gray #(.WIDTH(W), .ARCH(CA[i]), .SAT(CS[i])) dut (
            .clk(clk), .rst(rst), .ld(ld), .d(d[W-1:0]),
            .ci(ci), .dn(dn), .z(z), .zb(zb), .co(co)
        );

        assign zo[i]  = 13'(z);
        assign zbo[i] = 13'(zb);
        assign coo[i] = co;

        exp_t         q[$];
        bit           live = 1'b0;
        longint       mb = 0;
        logic [W-1:0] pz;

        // Reference: plain binary count with the end-of-range rules, recoded to Gray.
        always @(posedge clk) begin
            exp_t   e;
            longint top;
            longint old;
            top  = (longint'(1) << W) - 1;
            old  = mb;
            e    = '0;
            if (rst) begin
                mb   = 0;
                live = 1'b1;
            end else if (ld) begin
                mb = g2b(d, W);
            end else if (ci) begin
                e.sb = 1'b1;
                if (!dn) begin
                    if (mb == top) begin
                        e.co = 1'b1;
                        if (CS[i] == 0) mb = 0;
                    end else begin
                        mb = mb + 1;
                    end
                end else begin
                    if (mb == 0) begin
                        e.co = 1'b1;
                        if (CS[i] == 0) mb = top;
                    end else begin
                        mb = mb - 1;
                    end
                end
            end else begin
                e.sb = 1'b1;
            end
            e.z    = 13'(mb ^ (mb >> 1));
            e.zb   = 13'(mb);
            e.hops = (mb != old) ? 2'd1 : 2'd0;
            if (live) q.push_back(e);
        end

        always @(negedge clk) begin
            exp_t e;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk($sformatf("sb_z[%0d]", i), 32'(z), 32'(e.z));
                chk($sformatf("sb_zb[%0d]", i), 32'(zb), 32'(e.zb));
                chk($sformatf("sb_co[%0d]", i), 32'(co), 32'(e.co));
                if (e.sb) chk($sformatf("sb_onebit[%0d]", i), 32'($countones(z ^ pz)), 32'(e.hops));
                pz = z;
            end
        end
    end

    task automatic step(input logic r, input logic l, input logic [12:0] dd, input logic c, input logic dir);
        @(negedge clk);
        rst = r;
        ld  = l;
        d   = dd;
        ci  = c;
        dn  = dir;
        @(posedge clk);
        #1;
    endtask

    localparam logic [3:0] UPZ [4] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};

    initial begin
        int bias;
        logic [12:0] dv;

        step(1, 0, 0, 0, 0);
        chk("rst_z", 32'(zo[0]), 32'h0);
        chk("rst_co", 32'(coo[0]), 32'h0);

        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1, 0);
            chk($sformatf("up_z%0d", k), 32'(zo[0]), 32'(UPZ[k]));
            chk($sformatf("up_zb%0d", k), 32'(zbo[0]), 32'(k + 1));
            chk($sformatf("up_co%0d", k), 32'(coo[0]), 32'h0);
        end

        step(0, 1, 13'h0008, 0, 0);
        chk("ld_top_zb", 32'(zbo[0]), 32'd15);
        step(0, 0, 0, 1, 0);
        chk("wrap_up_z", 32'(zo[0]), 32'h0);
        chk("wrap_up_co", 32'(coo[0]), 32'h1);
        chk("sat_up_z", 32'(zo[1]), 32'h8);
        chk("sat_up_co", 32'(coo[1]), 32'h1);
        step(0, 0, 0, 1, 0);
        chk("after_wrap_z", 32'(zo[0]), 32'h1);
        chk("after_wrap_co", 32'(coo[0]), 32'h0);
        chk("sat_hold_co", 32'(coo[1]), 32'h1);

        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        chk("wrap_dn_z", 32'(zo[0]), 32'h8);
        chk("wrap_dn_zb", 32'(zbo[0]), 32'd15);
        chk("wrap_dn_co", 32'(coo[0]), 32'h1);
        chk("sat_dn_z", 32'(zo[1]), 32'h0);
        chk("sat_dn_co", 32'(coo[1]), 32'h1);
        step(0, 0, 0, 1, 1);
        chk("dn_next_z", 32'(zo[0]), 32'h9);
        chk("dn_next_co", 32'(coo[0]), 32'h0);
        chk("sat_dn2_co", 32'(coo[1]), 32'h1);

        step(0, 1, 13'h0005, 1, 0);
        chk("ld_wins_z", 32'(zo[0]), 32'h5);
        chk("ld_wins_co", 32'(coo[0]), 32'h0);
        step(0, 0, 0, 0, 1);
        chk("hold_z", 32'(zo[0]), 32'h5);
        step(1, 1, 13'h0005, 1, 0);
        chk("rst_wins_z", 32'(zo[0]), 32'h0);
        chk("rst_wins_z_sat", 32'(zo[1]), 32'h0);

        bias = 8;
        for (int n = 0; n < 20000; n++) begin
            if (n % 500 == 0) bias = (bias == 8) ? 1 : 8;
            case ($urandom_range(0, 5))
                0:       dv = 13'h0000;
                1:       dv = 13'h1000;
                2:       dv = 13'h0080;
                3:       dv = 13'h0008;
                4:       dv = 13'h0001;
                default: dv = 13'($urandom);
            endcase
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0), dv,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < bias));
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
